cmd_responder: RTL and testbench
================================

CMD_RESPONDER -- requirements
Module: cmd_responder

Interface
REQ-001 SHALL have parameter REG_COUNT, default 16, number of 32-bit registers (max 16).
REQ-002 SHALL have parameter VERSION, default 32'h0001_0000, value returned for reads of address 0x0E.
REQ-003 SHALL have parameter TIMEOUT, default 1024, frame-abort idle cycle count (used only under CMD_TIMEOUT_EN).
REQ-004 fx2_clk  in  1  sole clock; all logic SHALL be rising-edge.
REQ-005 reset_n  in  1  reset, asynchronous and active-low.
REQ-006 cmd  in  8  command byte from the USB interface block.
REQ-007 cmd_wr  in  1  cmd valid this cycle; no backpressure exists, so every strobe SHALL be consumed.
REQ-008 reply  out  8  reply byte presented to the USB interface block.
REQ-009 reply_rdy  out  1  a complete reply is buffered; SHALL remain high until the last byte is acked.
REQ-010 reply_ack  in  1  current reply byte consumed this cycle.
REQ-011 reply_end  out  1  current reply byte is the last of the frame.
REQ-012 regs_out  out  REG_COUNT*32  flat register contents; register n occupies bits [32n+31:32n].
REQ-013 reg_wr  out  1  one-cycle strobe on a register write.
REQ-014 reg_wr_addr  out  4  address written when reg_wr is high.

Function
REQ-015 Frame format SHALL be opcode, addr, then 4 data bytes for writes only (data is little-endian).
REQ-016 Opcodes SHALL be 0xAA (write) and 0xBB (read); any other opcode byte SHALL complete the frame immediately.
REQ-017 Parser states SHALL be P_OP, P_ADDR, P_DATA (2-bit byte counter 0..3) and P_EXEC; P_EXEC SHALL last one cycle and return to P_OP.
REQ-018 A write SHALL update the register in P_EXEC, with reg_wr pulsed the same cycle and the new value visible on regs_out the next cycle.
REQ-019 Replies SHALL be: write -> 1 byte 0xAC; read -> 4 bytes LSB first; bad opcode or addr >= REG_COUNT (other than 0x0E/0x0F) -> 1 byte 0xEE, with no register change.
REQ-020 Address 0x0E SHALL read VERSION; address 0x0F SHALL read status (bit0 = sticky overrun, bit1 = sticky timeout), and reading it SHALL clear both bits; writes to 0x0E/0x0F SHALL reply 0xAC and have no effect.
REQ-021 reply_rdy SHALL rise the cycle after P_EXEC; reply SHALL show byte 0 at that point.
REQ-022 Reply states SHALL be R_IDLE and R_SEND; each reply_ack SHALL advance to the next byte; reply_ack while reply_end is high SHALL return to R_IDLE with reply_rdy low the next cycle.
REQ-023 reply_end SHALL be combinational from the byte index and high only in R_SEND.
REQ-024 reply_ack while in R_IDLE SHALL be ignored.
REQ-025 Parsing SHALL continue during R_SEND; a frame reaching P_EXEC while in R_SEND SHALL still execute its write, but its reply SHALL be dropped and the overrun bit set.
REQ-026 cmd SHALL be ignored whenever cmd_wr is low.

Reset
REQ-027 Asserting reset_n low SHALL force the P_OP and R_IDLE states, reply = 8'h00, reply_rdy = 0, reply_end = 0, reg_wr = 0, and all registers and status bits to 0, in any state including mid-frame and mid-reply.
REQ-028 The first cmd_wr after reset release SHALL be treated as an opcode.

Configuration
REQ-029 With CMD_TIMEOUT_EN defined, a partial frame (not in P_OP) with no cmd_wr for TIMEOUT consecutive cycles SHALL return to P_OP, set the timeout bit and emit no reply.
REQ-030 Without CMD_TIMEOUT_EN, no counter SHALL exist, partial frames SHALL wait indefinitely, and status bit1 SHALL read 0.

Structure
REQ-031 Package timetag_cmd_pkg SHALL hold the opcodes, the reply codes (0xAC, 0xEE), the addresses 0x0E/0x0F, and the parser and reply state enums.
REQ-032 Submodule cmd_regfile SHALL hold the register array, write port and read mux; parser and reply FSMs SHALL stay in cmd_responder.

Verification
REQ-033 The bench SHALL drive AA 03 78 56 34 12 and require reg_wr with addr 3, regs_out[127:96] = 32'h12345678, reply 0xAC with reply_end on its ack.
REQ-034 The bench SHALL then drive BB 03 with reply_ack held high and require replies 78, 56, 34, 12, with reply_end only on 12 and reply_rdy low the next cycle.
REQ-035 The bench SHALL drive 5A and require a single reply 0xEE; it SHALL then drive BB 0E and require VERSION bytes 00 00 01 00.
REQ-036 The bench SHALL send a write frame while a 4-byte reply is unacked and require the write to take effect, no extra reply, and BB 0F to read 01 then 00 on a second read.
REQ-037 The bench SHALL apply reset_n low after AA 02 11 and require all outputs 0, then require AA 02 01 00 00 00 to write register 2 = 1.
REQ-038 Under CMD_TIMEOUT_EN with TIMEOUT = 8, the bench SHALL drive BB, idle 8 cycles, then drive BB 01 and require exactly one 4-byte reply and status bit1 set.

Source files
------------

// File: rtl/timetag_cmd_pkg.sv
// Shared definitions for the command responder: opcodes, reply codes,
// special register addresses and the parser / reply state encodings.
package timetag_cmd_pkg;

  localparam logic [7:0] OP_WRITE     = 8'hAA;
  localparam logic [7:0] OP_READ      = 8'hBB;
  localparam logic [7:0] RSP_ACK      = 8'hAC;
  localparam logic [7:0] RSP_ERR      = 8'hEE;
  localparam logic [7:0] ADDR_VERSION = 8'h0E;
  localparam logic [7:0] ADDR_STATUS  = 8'h0F;

  typedef enum logic [1:0] {
    P_OP   = 2'd0,
    P_ADDR = 2'd1,
    P_DATA = 2'd2,
    P_EXEC = 2'd3
  } parse_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_SEND = 1'b1
  } reply_state_t;

endpackage

// File: rtl/cmd_regfile.sv
// Register array for the command responder: one write port, one read mux
// and a flat view of every register for the surrounding logic.
module cmd_regfile
  import timetag_cmd_pkg::*;
#(
  parameter int REG_COUNT = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [3:0]              wr_addr,
  input  logic [31:0]             wr_data,
  input  logic [3:0]              rd_addr,
  output logic [31:0]             rd_data,
  output logic [REG_COUNT*32-1:0] regs_flat
);

  logic [31:0] regs [REG_COUNT];

  // Register storage: cleared by reset, written one word at a time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < REG_COUNT; i++)
        if (wr_addr == 4'(i)) regs[i] <= wr_data;
    end
  end

  // Read mux; addresses beyond the array read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < REG_COUNT; i++)
      if (rd_addr == 4'(i)) rd_data = regs[i];
  end

  // Flatten the array so register n sits at bits [32n+31:32n].
  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < REG_COUNT; i++) regs_flat[32*i +: 32] = regs[i];
  end

endmodule

// File: rtl/cmd_responder.sv
// Byte-stream command responder: parses write/read frames from the USB
// interface, executes them against cmd_regfile and streams back a reply.
// Optional feature macro CMD_TIMEOUT_EN: abort partial frames after
// TIMEOUT idle cycles and record it in status bit1.
module cmd_responder
  import timetag_cmd_pkg::*;
#(
  parameter int          REG_COUNT = 16,
  parameter logic [31:0] VERSION   = 32'h0001_0000,
  parameter int          TIMEOUT   = 1024
) (
  input  logic                    fx2_clk,
  input  logic                    reset_n,
  input  logic [7:0]              cmd,
  input  logic                    cmd_wr,
  output logic [7:0]              reply,
  output logic                    reply_rdy,
  input  logic                    reply_ack,
  output logic                    reply_end,
  output logic [REG_COUNT*32-1:0] regs_out,
  output logic                    reg_wr,
  output logic [3:0]              reg_wr_addr
);

  localparam logic [8:0] REG_LIMIT = 9'(REG_COUNT);

  parse_state_t pstate, pnext;
  reply_state_t rstate, rnext;

  logic [7:0]  op_q, addr_q;
  logic [31:0] data_q;
  logic [1:0]  byte_cnt;
  logic [31:0] rd_data;
  logic [31:0] rbuf;
  logic [1:0]  ridx, rlast;
  logic        sts_overrun, sts_timeout;
  logic        abort;

  logic        exec, is_write, is_read, addr_special, addr_in_range, frame_ok;
  logic        status_rd;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_last;

  // ---- Parser: byte capture ----
  // Parser state register.
  always_ff @(posedge fx2_clk or negedge reset_n) begin
    if (!reset_n) pstate <= P_OP;
    else          pstate <= pnext;
  end

  // Parser next state; a strobe during P_EXEC already starts the next frame.
  always_comb begin
    pnext = pstate;
    case (pstate)
      P_OP, P_EXEC: begin
        if (pstate == P_EXEC) pnext = P_OP;
        if (cmd_wr) pnext = (cmd == OP_WRITE || cmd == OP_READ) ? P_ADDR : P_EXEC;
      end
      P_ADDR:  if (cmd_wr) pnext = (op_q == OP_WRITE) ? P_DATA : P_EXEC;
      P_DATA:  if (cmd_wr && byte_cnt == 2'd3) pnext = P_EXEC;
      default: pnext = P_OP;
    endcase
    if (abort) pnext = P_OP;
  end

  // Frame field capture: opcode, address and little-endian write data.
  always_ff @(posedge fx2_clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      byte_cnt <= '0;
    end else if (cmd_wr) begin
      case (pstate)
        P_OP, P_EXEC: op_q <= cmd;
        P_ADDR: begin
          addr_q   <= cmd;
          byte_cnt <= '0;
        end
        P_DATA: begin
          data_q[8*byte_cnt +: 8] <= cmd;
          byte_cnt                <= byte_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // ---- Execute: decode the completed frame ----
  // Parser outputs: write strobe and the reply payload for this frame.
  always_comb begin
    exec          = (pstate == P_EXEC);
    is_write      = (op_q == OP_WRITE);
    is_read       = (op_q == OP_READ);
    addr_special  = (addr_q == ADDR_VERSION) || (addr_q == ADDR_STATUS);
    addr_in_range = ({1'b0, addr_q} < REG_LIMIT);
    frame_ok      = (is_write || is_read) && (addr_special || addr_in_range);
    reg_wr        = exec && is_write && addr_in_range && !addr_special;
    reg_wr_addr   = addr_q[3:0];
    status_rd     = exec && frame_ok && is_read && (addr_q == ADDR_STATUS);
    rsp_data      = {24'd0, RSP_ERR};
    rsp_last      = 2'd0;
    if (frame_ok) begin
      if (is_write) begin
        rsp_data = {24'd0, RSP_ACK};
      end else begin
        rsp_last = 2'd3;
        if (addr_q == ADDR_VERSION)     rsp_data = VERSION;
        else if (addr_q == ADDR_STATUS) rsp_data = {30'd0, sts_timeout, sts_overrun};
        else                            rsp_data = rd_data;
      end
    end
  end

  cmd_regfile #(
    .REG_COUNT (REG_COUNT)
  ) u_regfile (
    .clk       (fx2_clk),
    .rst_n     (reset_n),
    .wr_en     (reg_wr),
    .wr_addr   (addr_q[3:0]),
    .wr_data   (data_q),
    .rd_addr   (addr_q[3:0]),
    .rd_data   (rd_data),
    .regs_flat (regs_out)
  );

`ifdef CMD_TIMEOUT_EN
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT - 1);
  logic [31:0] idle_cnt;
  logic        partial;

  assign partial = (pstate == P_ADDR) || (pstate == P_DATA);
  assign abort   = partial && !cmd_wr && (idle_cnt == TO_LAST);

  // Idle-cycle counter for a partially received frame.
  always_ff @(posedge fx2_clk or negedge reset_n) begin
    if (!reset_n)                idle_cnt <= '0;
    else if (!partial || cmd_wr) idle_cnt <= '0;
    else                         idle_cnt <= idle_cnt + 32'd1;
  end

  // Sticky timeout flag, cleared by a status read.
  always_ff @(posedge fx2_clk or negedge reset_n) begin
    if (!reset_n)       sts_timeout <= 1'b0;
    else if (abort)     sts_timeout <= 1'b1;
    else if (status_rd && rstate == R_IDLE) sts_timeout <= 1'b0;
  end
`else
  assign abort       = 1'b0;
  assign sts_timeout = 1'b0;
`endif

  // Sticky overrun flag: set when a finished frame finds a reply in flight.
  always_ff @(posedge fx2_clk or negedge reset_n) begin
    if (!reset_n)                      sts_overrun <= 1'b0;
    else if (exec && rstate == R_SEND) sts_overrun <= 1'b1;
    else if (status_rd)                sts_overrun <= 1'b0;
  end

  // ---- Reply: byte streaming to the USB interface ----
  // Reply state register.
  always_ff @(posedge fx2_clk or negedge reset_n) begin
    if (!reset_n) rstate <= R_IDLE;
    else          rstate <= rnext;
  end

  // Reply next state: load on execute, leave after the last byte is acked.
  always_comb begin
    rnext = rstate;
    case (rstate)
      R_IDLE:  if (exec) rnext = R_SEND;
      R_SEND:  if (reply_ack && ridx == rlast) rnext = R_IDLE;
      default: rnext = R_IDLE;
    endcase
  end

  // Reply buffer and byte index.
  always_ff @(posedge fx2_clk or negedge reset_n) begin
    if (!reset_n) begin
      rbuf  <= '0;
      ridx  <= '0;
      rlast <= '0;
    end else if (exec && rstate == R_IDLE) begin
      rbuf  <= rsp_data;
      rlast <= rsp_last;
      ridx  <= '0;
    end else if (rstate == R_SEND && reply_ack) begin
      ridx  <= ridx + 2'd1;
    end
  end

  // Reply outputs, driven only while a reply is being sent.
  always_comb begin
    reply_rdy = (rstate == R_SEND);
    reply_end = (rstate == R_SEND) && (ridx == rlast);
    reply     = (rstate == R_SEND) ? rbuf[8*ridx +: 8] : 8'h00;
  end

endmodule

// File: tb/tb_cmd_responder.sv
// Directed bench for cmd_responder: write/read frames, special addresses,
// error replies, overrun, mid-frame reset and (optionally) frame timeout.
module tb_cmd_responder;

  localparam int REG_COUNT = 16;

  logic                    fx2_clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic [7:0]              cmd = 8'h00;
  logic                    cmd_wr = 1'b0;
  logic [7:0]              reply;
  logic                    reply_rdy;
  logic                    reply_ack = 1'b0;
  logic                    reply_end;
  logic [REG_COUNT*32-1:0] regs_out;
  logic                    reg_wr;
  logic [3:0]              reg_wr_addr;

  int n_checks = 0;
  int n_errors = 0;

  cmd_responder #(
    .REG_COUNT (REG_COUNT),
    .VERSION   (32'h0001_0000),
    .TIMEOUT   (8)
  ) dut (
    .fx2_clk     (fx2_clk),
    .reset_n     (reset_n),
    .cmd         (cmd),
    .cmd_wr      (cmd_wr),
    .reply       (reply),
    .reply_rdy   (reply_rdy),
    .reply_ack   (reply_ack),
    .reply_end   (reply_end),
    .regs_out    (regs_out),
    .reg_wr      (reg_wr),
    .reg_wr_addr (reg_wr_addr)
  );

  always #5 fx2_clk = ~fx2_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; the byte is captured on the next rising edge.
  task automatic send_byte(input logic [7:0] b);
    cmd    = b;
    cmd_wr = 1'b1;
    @(negedge fx2_clk);
    cmd_wr = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send_byte(bytes[i]);
  endtask

  // Drain a reply with reply_ack held high; wait_first skips one cycle when
  // called right after the frame reached P_EXEC.
  task automatic read_reply(input string tag, input logic [31:0] exp, input int n,
                            input bit wait_first);
    reply_ack = 1'b1;
    if (wait_first) @(negedge fx2_clk);
    for (int i = 0; i < n; i++) begin
      check({tag, "_rdy"}, 32'(reply_rdy), 32'd1);
      check({tag, "_byte"}, 32'(reply), 32'(exp[8*i +: 8]));
      check({tag, "_end"}, 32'(reply_end), 32'(i == n - 1));
      @(negedge fx2_clk);
    end
    reply_ack = 1'b0;
    check({tag, "_done"}, 32'(reply_rdy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", n_errors);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge fx2_clk);
    check("rst_rdy", 32'(reply_rdy), 32'd0);
    check("rst_reply", 32'(reply), 32'd0);
    check("rst_regs", 32'(|regs_out), 32'd0);
    @(negedge fx2_clk);
    reset_n = 1'b1;
    cmd = 8'hAA;  // ignored while cmd_wr is low
    repeat (2) @(negedge fx2_clk);

    // Write register 3
    send_frame('{8'hAA, 8'h03, 8'h78, 8'h56, 8'h34, 8'h12});
    check("wr_strobe", 32'(reg_wr), 32'd1);
    check("wr_addr", 32'(reg_wr_addr), 32'd3);
    check("wr_rdy_exec", 32'(reply_rdy), 32'd0);
    @(negedge fx2_clk);
    check("wr_reg3", regs_out[127:96], 32'h1234_5678);
    check("wr_strobe_off", 32'(reg_wr), 32'd0);
    read_reply("wr_ack", 32'h0000_00AC, 1, 1'b0);

    // Read register 3 with reply_ack held high from the start
    reply_ack = 1'b1;
    send_frame('{8'hBB, 8'h03});
    read_reply("rd3", 32'h1234_5678, 4, 1'b1);

    // Bad opcode, version read, invalid address, write to version
    send_frame('{8'h5A});
    read_reply("badop", 32'h0000_00EE, 1, 1'b1);
    send_frame('{8'hBB, 8'h0E});
    read_reply("version", 32'h0001_0000, 4, 1'b1);
    send_frame('{8'hBB, 8'h10});
    read_reply("rd_badaddr", 32'h0000_00EE, 1, 1'b1);
    send_frame('{8'hAA, 8'h20, 8'h01, 8'h02, 8'h03, 8'h04});
    check("wr_badaddr_strobe", 32'(reg_wr), 32'd0);
    read_reply("wr_badaddr", 32'h0000_00EE, 1, 1'b1);
    send_frame('{8'hAA, 8'h0E, 8'h01, 8'h02, 8'h03, 8'h04});
    check("wr_ver_strobe", 32'(reg_wr), 32'd0);
    read_reply("wr_ver", 32'h0000_00AC, 1, 1'b1);
    check("reg14_untouched", regs_out[14*32 +: 32], 32'd0);

    // Overrun: write while a read reply is unacked
    send_frame('{8'hBB, 8'h03});
    @(negedge fx2_clk);
    send_frame('{8'hAA, 8'h05, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
    check("ovr_strobe", 32'(reg_wr), 32'd1);
    @(negedge fx2_clk);
    check("ovr_reg5", regs_out[5*32 +: 32], 32'hDEAD_BEEF);
    read_reply("ovr_drain", 32'h1234_5678, 4, 1'b0);
    send_frame('{8'hBB, 8'h0F});
    read_reply("status1", 32'h0000_0001, 4, 1'b1);
    send_frame('{8'hBB, 8'h0F});
    read_reply("status2", 32'h0000_0000, 4, 1'b1);

    // Reset mid-frame with a reply pending
    send_frame('{8'hBB, 8'h03});
    send_frame('{8'hAA, 8'h02, 8'h11});
    reset_n = 1'b0;
    #1;
    check("mrst_rdy", 32'(reply_rdy), 32'd0);
    check("mrst_end", 32'(reply_end), 32'd0);
    check("mrst_reply", 32'(reply), 32'd0);
    check("mrst_wr", 32'(reg_wr), 32'd0);
    check("mrst_regs", 32'(|regs_out), 32'd0);
    @(negedge fx2_clk);
    reset_n = 1'b1;
    @(negedge fx2_clk);
    send_frame('{8'hAA, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00});
    check("post_rst_strobe", 32'(reg_wr), 32'd1);
    check("post_rst_addr", 32'(reg_wr_addr), 32'd2);
    @(negedge fx2_clk);
    check("post_rst_reg2", regs_out[95:64], 32'd1);
    read_reply("post_rst_ack", 32'h0000_00AC, 1, 1'b0);

`ifdef CMD_TIMEOUT_EN
    // Partial frame abandoned after 8 idle cycles
    send_byte(8'hBB);
    repeat (8) @(negedge fx2_clk);
    send_frame('{8'hBB, 8'h01});
    read_reply("to_read", 32'h0000_0000, 4, 1'b1);
    repeat (3) @(negedge fx2_clk);
    check("to_no_extra", 32'(reply_rdy), 32'd0);
    send_frame('{8'hBB, 8'h0F});
    read_reply("to_status", 32'h0000_0002, 4, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
